// File: rtl/picobello_pkg.sv
// picobello_pkg: shared constants and link-slice placement table for the picobello mesh
package picobello_pkg;
    localparam int unsigned LinkSliceDepth = 2;
    localparam int unsigned MeshX          = 4;
    localparam int unsigned MeshY          = 4;
    typedef enum logic [1:0] {North, East, South, West} route_dir_e;
    localparam logic [MeshX*MeshY*4-1:0] LinkSliceEn = '1;
    function automatic logic link_slice_en(input int unsigned x, input int unsigned y, input route_dir_e dir);
        return LinkSliceEn[(x * MeshY + y) * 4 + int'(dir)];
    endfunction
endpackage

// File: rtl/picobello_link_fifo.sv
// picobello_link_fifo: elastic FIFO with register-driven outputs and a saturating stall counter
module picobello_link_fifo #(
    parameter int unsigned Width    = 64,
    parameter int unsigned Depth    = 2,
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [Width-1:0]    data_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [Width-1:0]    data_o,
    input  logic                clr_i,
    output logic [CntWidth-1:0] stall_cnt_o
);
    localparam int unsigned PtrWidth = $clog2(Depth + 1);
    localparam int unsigned IdxWidth = Depth > 1 ? $clog2(Depth) : 1;
    localparam logic [PtrWidth-1:0] Last = PtrWidth'(Depth - 1);
    localparam logic [PtrWidth-1:0] Full = PtrWidth'(Depth);

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic [CntWidth-1:0] stall_q, stall_d;
    logic                push, pop;

    assign ready_o     = count_q != Full;
    assign valid_o     = count_q != '0;
    assign data_o      = mem_q[IdxWidth'(rd_ptr_q)];
    assign stall_cnt_o = stall_q;
    assign push        = valid_i & ready_o;
    assign pop         = valid_o & ready_i;

    // Next state: wrapping pointers, occupancy, and stall count that saturates and yields to clear
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q == Last ? '0 : wr_ptr_q + PtrWidth'(1)) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q == Last ? '0 : rd_ptr_q + PtrWidth'(1)) : rd_ptr_q;
        count_d  = count_q + PtrWidth'(push) - PtrWidth'(pop);
        stall_d  = clr_i ? '0 : (valid_o & ~ready_i & ~&stall_q) ? stall_q + CntWidth'(1) : stall_q;
    end

    // Payload storage; contents are meaningless until the slot is counted as occupied
    always_ff @(posedge clk_i) begin
        if (push) mem_q[IdxWidth'(wr_ptr_q)] <= data_i;
    end

    // Control registers, all discarded on reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end
endmodule

// File: rtl/picobello_mesh_link_slice.sv
// picobello_mesh_link_slice: registered slice on one directed mesh link, one FIFO per physical channel
module picobello_mesh_link_slice
    import picobello_pkg::*;
#(
    parameter int unsigned ReqWidth  = 64,
    parameter int unsigned RspWidth  = 64,
    parameter int unsigned WideWidth = 512,
    parameter int unsigned Depth     = LinkSliceDepth,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ReqWidth-1:0]   req_data_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [ReqWidth-1:0]   req_data_o,
    input  logic                  rsp_valid_i,
    output logic                  rsp_ready_o,
    input  logic [RspWidth-1:0]   rsp_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [RspWidth-1:0]   rsp_data_o,
    input  logic                  wide_valid_i,
    output logic                  wide_ready_o,
    input  logic [WideWidth-1:0]  wide_data_i,
    output logic                  wide_valid_o,
    input  logic                  wide_ready_i,
    output logic [WideWidth-1:0]  wide_data_o,
    input  logic                  stall_clr_i,
    output logic [3*CntWidth-1:0] stall_cnt_o
);
    picobello_link_fifo #(.Width(ReqWidth), .Depth(Depth), .CntWidth(CntWidth)) i_req (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (req_valid_i),
        .ready_o     (req_ready_o),
        .data_i      (req_data_i),
        .valid_o     (req_valid_o),
        .ready_i     (req_ready_i),
        .data_o      (req_data_o),
        .clr_i       (stall_clr_i),
        .stall_cnt_o (stall_cnt_o[CntWidth-1:0])
    );

    picobello_link_fifo #(.Width(RspWidth), .Depth(Depth), .CntWidth(CntWidth)) i_rsp (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (rsp_valid_i),
        .ready_o     (rsp_ready_o),
        .data_i      (rsp_data_i),
        .valid_o     (rsp_valid_o),
        .ready_i     (rsp_ready_i),
        .data_o      (rsp_data_o),
        .clr_i       (stall_clr_i),
        .stall_cnt_o (stall_cnt_o[2*CntWidth-1:CntWidth])
    );

    picobello_link_fifo #(.Width(WideWidth), .Depth(Depth), .CntWidth(CntWidth)) i_wide (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (wide_valid_i),
        .ready_o     (wide_ready_o),
        .data_i      (wide_data_i),
        .valid_o     (wide_valid_o),
        .ready_i     (wide_ready_i),
        .data_o      (wide_data_o),
        .clr_i       (stall_clr_i),
        .stall_cnt_o (stall_cnt_o[3*CntWidth-1:2*CntWidth])
    );
endmodule

// File: doc/picobello_mesh_link_slice.md
Name: picobello_mesh_link_slice

Overview:
- Pipeline stage inserted on one directed mesh link, between a tile's floo output port and the neighbouring tile's floo input port.
- Carries the three physical channels (narrow req, narrow rsp, wide) in one direction.
- Each channel has its own elastic FIFO, so no combinational path crosses the slice in either direction (valid/data forward, ready backward). This allows long inter-tile wires to close timing.
- Per-channel saturating back-pressure counters give performance visibility.

Parameters:
- ReqWidth, 64, payload width of the narrow req channel, excluding valid/ready.
- RspWidth, 64, payload width of the narrow rsp channel, excluding valid/ready.
- WideWidth, 512, payload width of the wide channel, excluding valid/ready.
- Depth, 2, entries per channel FIFO; legal range 1..8; 2 or more gives full throughput.
- CntWidth, 16, width of each stall counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_valid_i / req_ready_o / req_data_i  in / out / in  1 / 1 / ReqWidth  upstream narrow req
- req_valid_o / req_ready_i / req_data_o  out / in / out  1 / 1 / ReqWidth  downstream narrow req
- rsp_valid_i / rsp_ready_o / rsp_data_i  in / out / in  1 / 1 / RspWidth  upstream narrow rsp
- rsp_valid_o / rsp_ready_i / rsp_data_o  out / in / out  1 / 1 / RspWidth  downstream narrow rsp
- wide_valid_i / wide_ready_o / wide_data_i  in / out / in  1 / 1 / WideWidth  upstream wide
- wide_valid_o / wide_ready_i / wide_data_o  out / in / out  1 / 1 / WideWidth  downstream wide
- stall_clr_i  in  1  synchronous clear of all stall counters
- stall_cnt_o  out  3*CntWidth  stall counters packed as {wide, rsp, req}, req in the LSBs

Behaviour:
- Clock and reset: single clock clk_i. Reset is synchronous and active-low on rst_ni. All state is sampled on the rising edge.
- Reset values: every *_valid_o = 0; every *_ready_o = 1 (FIFO empty); all stall counters = 0. *_data_o is don't-care while valid is low; the implementation drives it from the read slot.
- Channel independence: the three channels are fully independent, with no ordering or arbitration between them.
- FIFO state: write pointer, read pointer and a count register, each width $clog2(Depth+1). Pointers wrap from Depth-1 to 0; non-power-of-two Depth must work.
- ready_o: ready_o = (count != Depth). It is a pure function of registers with no combinational dependence on ready_i.
- valid_o and data_o: valid_o = (count != 0); data_o = storage[rd_ptr]. Both are register-driven.
- Push and pop: push = valid_i & ready_o; pop = valid_o & ready_i.
  - On push, the slot is written and wr_ptr advances.
  - On pop, rd_ptr advances.
  - count updates by +push-pop, so simultaneous push and pop leaves count unchanged.
- Latency: a flit accepted in cycle N is visible on the output in cycle N+1 at the earliest. There is no bypass when empty.
- Throughput: with Depth ≥ 2 and no downstream stall, one flit per cycle is sustained indefinitely. With Depth = 1, one flit every 2 cycles.
- Full condition: ready_o = 0 for as long as count == Depth, even if ready_i = 1 in the same cycle. A pop while full re-asserts ready_o in the next cycle.
- Flit integrity: flits are never dropped, duplicated or reordered within a channel. Data of a held output flit must not change while valid_o = 1 and ready_i = 0.
- Stall counter (per channel): increments in every cycle where valid_o = 1 and ready_i = 0. It saturates at 2^CntWidth-1 and never wraps.
- stall_clr_i: when high, all counters become 0 in the next cycle; clear wins over a simultaneous increment.
- Reset mid-operation: all in-flight flits are discarded. Pointers, counts and counters return to 0. Outputs take reset values in the cycle after rst_ni is sampled low.
- Protocol assertions: once valid_i is asserted it is held with stable data until accepted (upstream rule). The slice obeys the same rule on its outputs.

Decomposition:
- Shared package (picobello_pkg):
  - LinkSliceDepth constant (default 2).
  - Per-link enable table indexed by x, y and direction, marking which mesh links get a slice.
- Payload types: channel widths are taken from $bits of floo_req_t, floo_rsp_t and floo_wide_t (minus the valid/ready bits) in floo_picobello_noc_pkg at the instantiation site.
- Sub-module: picobello_link_fifo (params Width, Depth, CntWidth), one instance per channel. It contains the FIFO and its stall counter. The top level only wires three instances and packs stall_cnt_o.

Test Plan:
1. Reset then idle: hold rst_ni low 2 cycles, release → all *_valid_o = 0, *_ready_o = 1, stall_cnt_o = 0.
2. Streaming, Depth = 2: push req flits 0x1..0x10 on consecutive cycles with req_ready_i = 1 → req_data_o shows 0x1..0x10 in order, first at cycle +1, 16 consecutive valid cycles, req_ready_o never deasserts.
3. Back-pressure: wide_ready_i = 0, push 3 flits → 2 accepted, wide_ready_o = 0 from the 3rd cycle on, wide stall counter increments every cycle. Raise wide_ready_i for 1 cycle → wide_ready_o = 1 in the next cycle and output order is preserved.
4. Saturation: CntWidth = 4, hold rsp valid-but-stalled for 20 cycles → rsp counter reads 15. Then assert stall_clr_i together with an ongoing stall → reads 0 in the next cycle.
5. Channel independence: stall the req channel while streaming 8 rsp and 8 wide flits → rsp and wide deliver all flits at full rate, and only the req counter is non-zero.
6. Mid-traffic reset: with 2 wide flits buffered, pulse rst_ni low 1 cycle → wide_valid_o = 0 and wide_ready_o = 1 in the next cycle. No stale flit appears afterwards; a new flit 0xAB emerges 1 cycle after it is pushed.
